nec_ir_tx: RTL and testbench
============================

# nec_ir_tx

NEC-protocol infrared frame generator; upstream companion of the IR receive decoder. It accepts a 16-bit address and an 8-bit command through a start/ready handshake, and serialises a full NEC frame or a repeat code. Output is both a demodulated active-low line, wired straight into the receiver's IRDA_RXD for loopback test, and a 38 kHz modulated LED drive.

## Interface
- CLK_HZ, 50_000_000: clock frequency; documents the cycle constants below.
- LEAD_MARK, 450000: 9 ms leader burst, in cycles.
- LEAD_SPACE, 225000: 4.5 ms leader space.
- RPT_SPACE, 112500: 2.25 ms repeat-code space.
- BIT_MARK, 28000: 560 µs burst, used for every bit and for the stop burst.
- ZERO_SPACE, 28000: space for logic 0 (bit period 1.12 ms).
- ONE_SPACE, 84500: space for logic 1 (bit period 2.25 ms).
- GAP_CYC, 2000000: 40 ms mandatory idle after each transmission.
- CARR_HALF, 658: half period of the ≈38 kHz carrier.

Ports:
- CLOCK_50  in  1: clock.
- RSTN  in  1: reset, asynchronous, active-low.
- START  in  1: one-cycle request to send a full frame.
- REPEAT  in  1: one-cycle request to send a repeat code.
- ADDR  in  16: address, sampled when START is accepted.
- CMD  in  8: command, sampled when START is accepted.
- READY  out  1: high only in IDLE.
- DONE  out  1: one-cycle pulse on GAP→IDLE.
- IRDA_TXD  out  1: demodulated line; low = burst, idle high.
- IR_LED  out  1: carrier during bursts, 0 otherwise.

## Operation
- Reset values: READY=1, DONE=0, IRDA_TXD=1, IR_LED=0. The FSM is in IDLE and all counters are 0.
- Frame word: {~CMD, CMD, ADDR}, 32 bits, transmitted LSB first (bit 0 = ADDR[0]).
- START wins when START and REPEAT are both high. Requests arriving while READY=0 are dropped, with no queuing.
- FSM states and transitions:
  - IDLE → LEAD_MARK on START or REPEAT; a rpt flag latches which request was taken.
  - LEAD_MARK → LEAD_SPACE after LEAD_MARK cycles.
  - LEAD_SPACE lasts LEAD_SPACE cycles, or RPT_SPACE cycles if rpt is set. It then goes to STOP_MARK if rpt, else BIT_MARK.
  - BIT_MARK → BIT_SPACE after BIT_MARK cycles.
  - BIT_SPACE lasts ZERO_SPACE or ONE_SPACE cycles, selected by the current bit. It then goes to BIT_MARK with bit index +1, or to STOP_MARK after bit 31.
  - STOP_MARK → GAP after BIT_MARK cycles.
  - GAP → IDLE after GAP_CYC cycles, pulsing DONE.
- IRDA_TXD is 0 in LEAD_MARK, BIT_MARK and STOP_MARK, and 1 in all other states.
- IR_LED equals the carrier square wave ANDed with ~IRDA_TXD. The carrier phase restarts high at the start of every mark.
- Counters:
  - Duration counter is 21 bits, reloaded to 0 on every state change. The terminal test is count == duration-1, so each state lasts exactly its parameter.
  - Bit index is 5 bits and never wraps mid-frame.
  - Carrier counter is 10 bits.
- ADDR and CMD may change freely after acceptance; the frame uses the latched word.

## Timing
- IRDA_TXD and READY are registered. START sampled in cycle k gives READY=0 and IRDA_TXD=0 in cycle k+1.
- Falling edge to falling edge:
  - Leader: 675000 cycles.
  - Bit 0: 56000 cycles.
  - Bit 1: 112500 cycles.
  - Repeat leader: 562500 cycles.
  - All of these sit inside the receiver's acceptance windows.
- Full-frame length, START to DONE: 675000 + Σbit periods + 28000 + GAP_CYC + 1 cycles.
- Reset asserted mid-frame: all outputs return to reset values immediately, no stop burst is sent, and the latched word is cleared.

## Structure
- Package nec_ir_pkg holds:
  - Default timing constants, shared with the receiver's windows.
  - State enum with 3-bit encoding: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
  - Frame-word build function.
- Sub-module ir_carrier_gen: enable input, CARR_HALF-parameterised toggle counter with sync restart, one-bit output.

## Test plan
- START with ADDR=16'h00FF, CMD=8'h45, looped to the receiver → receiver DATA = 32'hBA4500FF; DONE pulses exactly once.
- Same frame, measure IRDA_TXD falling-edge intervals → 675000, then 8×112500, then 8×56000, …, ending with a 28000-cycle stop low.
- REPEAT alone → exactly 450000 low, 112500 high, 28000 low, then GAP; receiver DATA unchanged.
- START and REPEAT in the same cycle → full frame sent. A second START while READY=0 → ignored, with only one DONE.
- During a mark, IR_LED toggles every 658 cycles starting high. During spaces and idle, IR_LED = 0.
- RSTN pulsed low during bit 10 → IRDA_TXD=1, READY=1 and IR_LED=0 asynchronously; a fresh START afterwards produces a correct frame.

Source files
------------

// File: rtl/nec_ir_pkg.sv
// Shared NEC IR definitions: default cycle constants at 50 MHz, the transmitter
// state encoding and the on-air frame word layout.
package nec_ir_pkg;

  localparam int DEF_CLK_HZ     = 50_000_000;
  localparam int DEF_LEAD_MARK  = 450000;
  localparam int DEF_LEAD_SPACE = 225000;
  localparam int DEF_RPT_SPACE  = 112500;
  localparam int DEF_BIT_MARK   = 28000;
  localparam int DEF_ZERO_SPACE = 28000;
  localparam int DEF_ONE_SPACE  = 84500;
  localparam int DEF_GAP_CYC    = 2000000;
  localparam int DEF_CARR_HALF  = 658;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_STOP_MARK  = 3'd5,
    S_GAP        = 3'd6
  } state_t;

  // Bit 0 of the word goes on air first.
  function automatic logic [31:0] frame_word(input logic [15:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, addr};
  endfunction

  function automatic logic is_mark(input state_t s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier square wave for the IR LED; restart forces the phase high so every
// burst begins with a full high half period.
module ir_carrier_gen #(
  parameter int CARR_HALF = 658
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic restart,
  output logic carr
);

  logic [9:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      carr <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      carr <= 1'b1;
    end else if (en) begin
      if (cnt == 10'(CARR_HALF - 1)) begin
        cnt  <= '0;
        carr <= ~carr;
      end else begin
        cnt <= cnt + 10'd1;
      end
    end
  end

endmodule

// File: rtl/nec_ir_tx.sv
// NEC infrared frame transmitter: serialises a full address/command frame or a
// repeat code onto an active-low line plus a carrier-modulated LED drive.
module nec_ir_tx
  import nec_ir_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int LEAD_MARK  = DEF_LEAD_MARK,
  parameter int LEAD_SPACE = DEF_LEAD_SPACE,
  parameter int RPT_SPACE  = DEF_RPT_SPACE,
  parameter int BIT_MARK   = DEF_BIT_MARK,
  parameter int ZERO_SPACE = DEF_ZERO_SPACE,
  parameter int ONE_SPACE  = DEF_ONE_SPACE,
  parameter int GAP_CYC    = DEF_GAP_CYC,
  parameter int CARR_HALF  = DEF_CARR_HALF
) (
  input  logic        CLOCK_50,
  input  logic        RSTN,
  input  logic        START,
  input  logic        REPEAT,
  input  logic [15:0] ADDR,
  input  logic [7:0]  CMD,
  output logic        READY,
  output logic        DONE,
  output logic        IRDA_TXD,
  output logic        IR_LED
);

  // Half period is held inside the carrier's 10-bit counter and below half a second.
  localparam int CARR_HALF_C = (CARR_HALF < 1) ? 1 :
                               ((CARR_HALF > 1023) || (CARR_HALF > CLK_HZ / 2)) ? 1023 : CARR_HALF;

  state_t      state, state_nx;
  logic [20:0] cnt;
  logic [20:0] dur;
  logic        last;
  logic [4:0]  bit_idx;
  logic [31:0] word;
  logic        rpt;
  logic        carr;
  logic        mark_nx;
  logic        restart;

  always_comb begin
    dur = 21'd1;
    case (state)
      S_LEAD_MARK:              dur = 21'(LEAD_MARK);
      S_LEAD_SPACE:             dur = rpt ? 21'(RPT_SPACE) : 21'(LEAD_SPACE);
      S_BIT_MARK, S_STOP_MARK:  dur = 21'(BIT_MARK);
      S_BIT_SPACE:              dur = word[bit_idx] ? 21'(ONE_SPACE) : 21'(ZERO_SPACE);
      S_GAP:                    dur = 21'(GAP_CYC);
      default:                  dur = 21'd1;
    endcase
  end

  assign last = (cnt == dur - 21'd1);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:       if (START || REPEAT) state_nx = S_LEAD_MARK;
      S_LEAD_MARK:  if (last) state_nx = S_LEAD_SPACE;
      S_LEAD_SPACE: if (last) state_nx = rpt ? S_STOP_MARK : S_BIT_MARK;
      S_BIT_MARK:   if (last) state_nx = S_BIT_SPACE;
      S_BIT_SPACE:  if (last) state_nx = (bit_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
      S_STOP_MARK:  if (last) state_nx = S_GAP;
      S_GAP:        if (last) state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN) begin
    if (!RSTN) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      word     <= '0;
      rpt      <= 1'b0;
      READY    <= 1'b1;
      DONE     <= 1'b0;
      IRDA_TXD <= 1'b1;
    end else begin
      state <= state_nx;
      if (state_nx != state || state == S_IDLE) cnt <= '0;
      else                                      cnt <= cnt + 21'd1;
      if (state == S_IDLE && (START || REPEAT)) begin
        rpt     <= ~START;
        bit_idx <= '0;
        if (START) word <= frame_word(ADDR, CMD);
      end
      if (state == S_BIT_SPACE && last && bit_idx != 5'd31) bit_idx <= bit_idx + 5'd1;
      // Outputs are decoded from the next state so they switch with the state register.
      READY    <= (state_nx == S_IDLE);
      DONE     <= (state == S_GAP) && (state_nx == S_IDLE);
      IRDA_TXD <= ~is_mark(state_nx);
    end
  end

  assign mark_nx = is_mark(state_nx);
  assign restart = mark_nx && !is_mark(state);

  ir_carrier_gen #(
    .CARR_HALF (CARR_HALF_C)
  ) u_carrier (
    .clk     (CLOCK_50),
    .rstn    (RSTN),
    .en      (mark_nx),
    .restart (restart),
    .carr    (carr)
  );

  assign IR_LED = carr & ~IRDA_TXD;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Directed bench for nec_ir_tx with shortened timing constants so whole frames fit
// in a short run; frames are decoded from IRDA_TXD run lengths.
module tb_nec_ir_tx;

  localparam int LM = 40;
  localparam int LS = 20;
  localparam int RS = 10;
  localparam int BM = 4;
  localparam int ZS = 4;
  localparam int OS = 12;
  localparam int GC = 30;
  localparam int CH = 3;
  localparam int LIMIT = 5000;

  logic        CLOCK_50 = 1'b0;
  logic        RSTN = 1'b0;
  logic        START = 1'b0;
  logic        REPEAT = 1'b0;
  logic [15:0] ADDR = '0;
  logic [7:0]  CMD = '0;
  logic        READY, DONE, IRDA_TXD, IR_LED;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;

  typedef struct {
    logic        start;
    logic        rpt_req;
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic [31:0] exp_word;
    logic        exp_rpt;
    logic        poke;
  } vec_t;

  vec_t vecs[5];

  nec_ir_tx #(
    .CLK_HZ     (50_000_000),
    .LEAD_MARK  (LM),
    .LEAD_SPACE (LS),
    .RPT_SPACE  (RS),
    .BIT_MARK   (BM),
    .ZERO_SPACE (ZS),
    .ONE_SPACE  (OS),
    .GAP_CYC    (GC),
    .CARR_HALF  (CH)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RSTN     (RSTN),
    .START    (START),
    .REPEAT   (REPEAT),
    .ADDR     (ADDR),
    .CMD      (CMD),
    .READY    (READY),
    .DONE     (DONE),
    .IRDA_TXD (IRDA_TXD),
    .IR_LED   (IR_LED)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) if (DONE === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_int(input string nm, input int got, input int exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic check_vec(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h, required %08h", nm, got, exp);
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b, required %b", nm, got, exp);
    end
  endtask

  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (IRDA_TXD === lvl && n < LIMIT) begin
      n++;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int n, bad, d0, lead_exp;
    logic [31:0] w;
    d0 = done_cnt;
    @(negedge CLOCK_50);
    START = v.start; REPEAT = v.rpt_req; ADDR = v.addr; CMD = v.cmd;
    @(negedge CLOCK_50);
    START = 1'b0; REPEAT = 1'b0; ADDR = ~v.addr; CMD = ~v.cmd;
    check_bit("ready_busy", READY, 1'b0);
    check_bit("txd_first_low", IRDA_TXD, 1'b0);
    lead_exp = LM;
    if (v.poke) begin
      START = 1'b1; ADDR = 16'hDEAD; CMD = 8'h5C;
      @(negedge CLOCK_50);
      START = 1'b0;
      lead_exp = LM - 1;
    end
    measure(1'b0, n);
    check_int("lead_mark", n, lead_exp);
    measure(1'b1, n);
    check_int("lead_space", n, v.exp_rpt ? RS : LS);
    if (!v.exp_rpt) begin
      bad = 0;
      w = '0;
      for (int b = 0; b < 32; b++) begin
        measure(1'b0, n);
        if (n != BM) bad++;
        measure(1'b1, n);
        if (n == OS) w[b] = 1'b1;
        else if (n != ZS) bad++;
      end
      check_int("bit_timing_errors", bad, 0);
      check_vec("frame_word", w, v.exp_word);
    end
    measure(1'b0, n);
    check_int("stop_mark", n, BM);
    n = 0;
    while (DONE !== 1'b1 && n < LIMIT) begin
      n++;
      @(negedge CLOCK_50);
    end
    check_int("gap_len", n, GC);
    check_bit("ready_at_done", READY, 1'b1);
    check_bit("led_idle", IR_LED, 1'b0);
    @(negedge CLOCK_50);
    check_bit("done_one_cycle", DONE, 1'b0);
    check_int("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    int bad, falls, n;
    logic prev;

    vecs[0] = '{1'b1, 1'b0, 16'h00FF, 8'h45, 32'hBA4500FF, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 8'h00, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'h1234, 8'hA5, 32'h5AA51234, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 32'hFF00FFFF, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 16'h0000, 8'hFF, 32'h00FF0000, 1'b0, 1'b0};

    repeat (3) @(negedge CLOCK_50);
    check_bit("rst_ready", READY, 1'b1);
    check_bit("rst_done", DONE, 1'b0);
    check_bit("rst_txd", IRDA_TXD, 1'b1);
    check_bit("rst_led", IR_LED, 1'b0);
    RSTN = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    check_bit("idle_ready", READY, 1'b1);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Carrier phase across the leader and the first bit, then reset during bit 10.
    @(negedge CLOCK_50);
    START = 1'b1; ADDR = 16'h00FF; CMD = 8'h45;
    @(negedge CLOCK_50);
    START = 1'b0;
    bad = 0;
    for (int i = 0; i < LM; i++) begin
      if (IR_LED !== (((i / CH) % 2) == 0)) bad++;
      @(negedge CLOCK_50);
    end
    check_int("carrier_leader_errors", bad, 0);
    bad = 0;
    for (int i = 0; i < LS; i++) begin
      if (IR_LED !== 1'b0) bad++;
      @(negedge CLOCK_50);
    end
    check_int("led_space_errors", bad, 0);
    bad = 0;
    for (int i = 0; i < BM; i++) begin
      if (IR_LED !== (((i / CH) % 2) == 0)) bad++;
      @(negedge CLOCK_50);
    end
    check_int("carrier_restart_errors", bad, 0);

    falls = 2;
    prev = IRDA_TXD;
    n = 0;
    while (falls < 12 && n < LIMIT) begin
      @(negedge CLOCK_50);
      if (prev === 1'b1 && IRDA_TXD === 1'b0) falls++;
      prev = IRDA_TXD;
      n++;
    end
    check_int("reach_bit10", falls, 12);
    @(negedge CLOCK_50);
    check_bit("bit10_mark_low", IRDA_TXD, 1'b0);
    RSTN = 1'b0;
    #1;
    check_bit("async_rst_txd", IRDA_TXD, 1'b1);
    check_bit("async_rst_ready", READY, 1'b1);
    check_bit("async_rst_led", IR_LED, 1'b0);
    @(negedge CLOCK_50);
    RSTN = 1'b1;
    @(negedge CLOCK_50);
    check_bit("post_rst_txd", IRDA_TXD, 1'b1);
    run_frame(vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
